// File: rtl/sample_sched.sv
// sample_sched: sample-rate scheduler for the audio equalizer datapath.
// A programmable clock-enable divider starts one sample per wrap, which
// is sequenced ADC capture -> filter bank -> DAC load via start/done handshakes.
// Ticks that arrive while a sample is still in flight are dropped and counted.
// Optional build macro SAMPLE_WDOG_EN adds a per-stage watchdog (wd_timeout);
// without it wd_timeout is tied 0 and the FSM waits indefinitely.
module sample_sched #(
   parameter int DIV_W    = 8,
   parameter int DEF_DIV  = 141,
   parameter int OVR_W    = 4,
   parameter int WD_LIMIT = 255
) (
   input  logic             clk_in,
   input  logic             clk_rst,
   input  logic             enable,
   input  logic [DIV_W-1:0] cfg_div,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   output logic             sample_tick,
   output logic             adc_start,
   input  logic             adc_done,
   output logic             filt_start,
   input  logic             filt_done,
   output logic             dac_load,
   input  logic             dac_ready,
   output logic             busy,
   output logic             overrun,
   input  logic             overrun_clr,
   output logic [OVR_W-1:0] ovr_cnt,
   output logic             wd_timeout
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ADC  = 2'd1;
   localparam logic [1:0] S_FILT = 2'd2;
   localparam logic [1:0] S_DAC  = 2'd3;

   logic [DIV_W-1:0] r_cnt;
   logic [DIV_W-1:0] r_div;
   logic [DIV_W-1:0] r_pend_div;
   logic             r_cfg_ready;
   logic [1:0]       r_state;
   logic [1:0]       w_state_nxt;
   logic             r_tick;
   logic             r_adc_start;
   logic             r_filt_start;
   logic             r_dac_load;
   logic             r_overrun;
   logic [OVR_W-1:0] r_ovr_cnt;
   logic             w_wrap;
   logic             w_drop;
   logic             w_cfg_xfer;

   assign w_wrap     = enable && (r_cnt == r_div);
   // A wrap while a sample is still in flight (state before the edge) is dropped.
   assign w_drop     = w_wrap && (r_state != S_IDLE);
   assign w_cfg_xfer = cfg_valid && r_cfg_ready;

`ifdef SAMPLE_WDOG_EN
   localparam int WD_W = $clog2(WD_LIMIT + 1);
   logic [WD_W-1:0] r_wd_cnt;
   logic            r_wd_timeout;
   logic            w_wd_fire;

   assign w_wd_fire = (r_state != S_IDLE) && (r_wd_cnt == WD_W'(WD_LIMIT - 1));
`endif

   // Period counter: free-runs 0..div_reg while enabled, parked at 0 otherwise.
   always_ff @(posedge clk_in) begin
      if (clk_rst) begin
         r_cnt <= '0;
      end else if (!enable || w_wrap) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + DIV_W'(1);
      end
   end

   // Divisor port: accept one value, hold it until a sample boundary (or idle divider).
   always_ff @(posedge clk_in) begin
      if (clk_rst) begin
         r_div       <= DIV_W'(DEF_DIV);
         r_pend_div  <= DIV_W'(DEF_DIV);
         r_cfg_ready <= 1'b1;
      end else if (w_cfg_xfer) begin
         r_pend_div  <= (cfg_div == '0) ? DIV_W'(1) : cfg_div;
         r_cfg_ready <= 1'b0;
      end else if (!r_cfg_ready && (w_wrap || !enable)) begin
         r_div       <= r_pend_div;
         r_cfg_ready <= 1'b1;
      end
   end

   // Next-state decode for the ADC -> FILT -> DAC sample sequence.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_wrap)    w_state_nxt = S_ADC;
         S_ADC:   if (adc_done)  w_state_nxt = S_FILT;
         S_FILT:  if (filt_done) w_state_nxt = S_DAC;
         S_DAC:   if (dac_ready) w_state_nxt = S_IDLE;
         default:                w_state_nxt = S_IDLE;
      endcase
`ifdef SAMPLE_WDOG_EN
      if (w_wd_fire) w_state_nxt = S_IDLE;
`endif
   end

   // State register and registered handshake outputs.
   always_ff @(posedge clk_in) begin
      if (clk_rst) begin
         r_state      <= S_IDLE;
         r_tick       <= 1'b0;
         r_adc_start  <= 1'b0;
         r_filt_start <= 1'b0;
         r_dac_load   <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_tick       <= w_wrap;
         r_adc_start  <= w_wrap && (r_state == S_IDLE);
         r_filt_start <= (r_state == S_ADC) && (w_state_nxt == S_FILT);
         r_dac_load   <= (w_state_nxt == S_DAC);
      end
   end

   // Overrun flag and saturating drop counter; a new drop beats a same-cycle clear.
   always_ff @(posedge clk_in) begin
      if (clk_rst) begin
         r_overrun <= 1'b0;
         r_ovr_cnt <= '0;
      end else if (w_drop) begin
         r_overrun <= 1'b1;
         if (overrun_clr) begin
            r_ovr_cnt <= OVR_W'(1);
         end else if (r_ovr_cnt != '1) begin
            r_ovr_cnt <= r_ovr_cnt + OVR_W'(1);
         end
      end else if (overrun_clr) begin
         r_overrun <= 1'b0;
         r_ovr_cnt <= '0;
      end
   end

`ifdef SAMPLE_WDOG_EN
   // Stage watchdog: cycles spent in the current busy state, restarted on each change.
   always_ff @(posedge clk_in) begin
      if (clk_rst) begin
         r_wd_cnt     <= '0;
         r_wd_timeout <= 1'b0;
      end else begin
         if ((w_state_nxt != r_state) || (r_state == S_IDLE)) begin
            r_wd_cnt <= '0;
         end else begin
            r_wd_cnt <= r_wd_cnt + WD_W'(1);
         end
         if (w_wd_fire) begin
            r_wd_timeout <= 1'b1;
         end else if (overrun_clr) begin
            r_wd_timeout <= 1'b0;
         end
      end
   end

   assign wd_timeout = r_wd_timeout;
`else
   assign wd_timeout = 1'b0;
`endif

   assign cfg_ready   = r_cfg_ready;
   assign sample_tick = r_tick;
   assign adc_start   = r_adc_start;
   assign filt_start  = r_filt_start;
   assign dac_load    = r_dac_load;
   assign busy        = (r_state != S_IDLE);
   assign overrun     = r_overrun;
   assign ovr_cnt     = r_ovr_cnt;

endmodule

// File: tb/tb_sample_sched.sv
// Testbench for sample_sched: expected tick times are queued as stimulus is
// applied and popped as the DUT produces sample_tick pulses.
module tb_sample_sched;

   logic       clk_in = 1'b0;
   logic       clk_rst;
   logic       enable;
   logic [7:0] cfg_div;
   logic       cfg_valid;
   logic       cfg_ready;
   logic       sample_tick;
   logic       adc_start;
   logic       adc_done;
   logic       filt_start;
   logic       filt_done;
   logic       dac_load;
   logic       dac_ready;
   logic       busy;
   logic       overrun;
   logic       overrun_clr;
   logic [3:0] ovr_cnt;
   logic       wd_timeout;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int n_load   = 0;
   int exp_q[$];

   sample_sched #(
      .DIV_W(8), .DEF_DIV(141), .OVR_W(4), .WD_LIMIT(16)
   ) dut (
      .clk_in(clk_in), .clk_rst(clk_rst), .enable(enable),
      .cfg_div(cfg_div), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .sample_tick(sample_tick), .adc_start(adc_start), .adc_done(adc_done),
      .filt_start(filt_start), .filt_done(filt_done), .dac_load(dac_load),
      .dac_ready(dac_ready), .busy(busy), .overrun(overrun),
      .overrun_clr(overrun_clr), .ovr_cnt(ovr_cnt), .wd_timeout(wd_timeout)
   );

   always #5 clk_in = ~clk_in;
   always @(posedge clk_in) cyc <= cyc + 1;

   // Advance on falling edges until a tick is seen or the budget expires (t = -1).
   task automatic wait_tick(input int limit, output int t);
      t = -1;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk_in);
         if (dac_load) n_load++;
         if (sample_tick) begin
            t = cyc;
            break;
         end
      end
   endtask

   task automatic test_reset();
      clk_rst = 1'b1;
      repeat (3) @(negedge clk_in);
      checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL rst_cfg_ready got=%b exp=1", cfg_ready); end
      checks++; if ({sample_tick, adc_start, filt_start, dac_load} !== 4'b0000) begin failures++; $display("FAIL rst_pulses got=%b exp=0000", {sample_tick, adc_start, filt_start, dac_load}); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
      checks++; if (overrun !== 1'b0 || ovr_cnt !== 4'd0) begin failures++; $display("FAIL rst_overrun got=%b/%0d exp=0/0", overrun, ovr_cnt); end
      checks++; if (wd_timeout !== 1'b0) begin failures++; $display("FAIL rst_wd got=%b exp=0", wd_timeout); end
      clk_rst = 1'b0;
   endtask

   task automatic test_default_period();
      int t, e, p;
      @(negedge clk_in);
      p = cyc;
      enable = 1'b1;
      for (int k = 1; k <= 3; k++) exp_q.push_back(p + 142 * k);
      for (int k = 0; k < 3; k++) begin
         n_load = 0;
         wait_tick(300, t);
         e = exp_q.pop_front();
         checks++; if (t !== e) begin failures++; $display("FAIL def_tick_time got=%0d exp=%0d", t, e); end
         checks++; if (adc_start !== 1'b1) begin failures++; $display("FAIL def_adc_start got=%b exp=1", adc_start); end
         checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL def_overrun got=%b exp=0", overrun); end
         if (k > 0) begin
            checks++; if (n_load !== 1) begin failures++; $display("FAIL def_dac_loads got=%0d exp=1", n_load); end
         end
      end
      @(negedge clk_in);
      checks++; if (filt_start !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL def_filt_start got=%b/%b exp=1/1", filt_start, busy); end
      @(negedge clk_in);
      checks++; if (dac_load !== 1'b1) begin failures++; $display("FAIL def_dac_load got=%b exp=1", dac_load); end
   endtask

   task automatic test_cfg();
      int t, e, t0;
      wait_tick(300, t0);
      repeat (50) @(negedge clk_in);
      cfg_div = 8'd9;
      cfg_valid = 1'b1;
      @(negedge clk_in);
      cfg_valid = 1'b0;
      checks++; if (cfg_ready !== 1'b0) begin failures++; $display("FAIL cfg_ready_drop got=%b exp=0", cfg_ready); end
      exp_q.push_back(t0 + 142);
      exp_q.push_back(t0 + 152);
      exp_q.push_back(t0 + 162);
      for (int k = 0; k < 3; k++) begin
         wait_tick(300, t);
         e = exp_q.pop_front();
         checks++; if (t !== e) begin failures++; $display("FAIL cfg_tick_time got=%0d exp=%0d", t, e); end
         if (k == 0) begin
            checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL cfg_ready_return got=%b exp=1", cfg_ready); end
         end
      end
   endtask

   task automatic test_overrun();
      int t, e, t1;
      wait_tick(50, t);
      repeat (5) @(negedge clk_in);
      filt_done = 1'b0;
      wait_tick(50, t1);
      checks++; if (adc_start !== 1'b1) begin failures++; $display("FAIL ovr_first_start got=%b exp=1", adc_start); end
      for (int k = 1; k <= 3; k++) exp_q.push_back(t1 + 10 * k);
      for (int k = 1; k <= 2; k++) begin
         wait_tick(50, t);
         e = exp_q.pop_front();
         checks++; if (t !== e) begin failures++; $display("FAIL ovr_tick_time got=%0d exp=%0d", t, e); end
         checks++; if (adc_start !== 1'b0) begin failures++; $display("FAIL ovr_drop_nostart got=%b exp=0", adc_start); end
         checks++; if (overrun !== 1'b1 || ovr_cnt !== 4'(k)) begin failures++; $display("FAIL ovr_count got=%b/%0d exp=1/%0d", overrun, ovr_cnt, k); end
      end
      repeat (5) @(negedge clk_in);
      filt_done = 1'b1;
      wait_tick(50, t);
      e = exp_q.pop_front();
      checks++; if (t !== e) begin failures++; $display("FAIL ovr_resume_time got=%0d exp=%0d", t, e); end
      checks++; if (adc_start !== 1'b1 || ovr_cnt !== 4'd2) begin failures++; $display("FAIL ovr_resume got=%b/%0d exp=1/2", adc_start, ovr_cnt); end
      @(negedge clk_in);
      overrun_clr = 1'b1;
      @(negedge clk_in);
      overrun_clr = 1'b0;
      filt_done = 1'b0;
      checks++; if (overrun !== 1'b0 || ovr_cnt !== 4'd0) begin failures++; $display("FAIL ovr_clear got=%b/%0d exp=0/0", overrun, ovr_cnt); end
      wait_tick(50, t);
      repeat (9) @(negedge clk_in);
      overrun_clr = 1'b1;
      @(negedge clk_in);
      overrun_clr = 1'b0;
      checks++; if (sample_tick !== 1'b1 || overrun !== 1'b1 || ovr_cnt !== 4'd1) begin failures++; $display("FAIL ovr_set_wins got=%b/%b/%0d exp=1/1/1", sample_tick, overrun, ovr_cnt); end
      filt_done = 1'b1;
   endtask

   task automatic test_div_zero();
      int t, e, t0;
      wait_tick(50, t0);
      cfg_div = 8'd0;
      cfg_valid = 1'b1;
      @(negedge clk_in);
      cfg_valid = 1'b0;
      checks++; if (cfg_ready !== 1'b0) begin failures++; $display("FAIL div0_ready got=%b exp=0", cfg_ready); end
      for (int k = 0; k < 4; k++) exp_q.push_back(t0 + 10 + 2 * k);
      for (int k = 0; k < 4; k++) begin
         wait_tick(50, t);
         e = exp_q.pop_front();
         checks++; if (t !== e) begin failures++; $display("FAIL div0_tick_time got=%0d exp=%0d", t, e); end
      end
   endtask

   task automatic test_saturate();
      int t, exp_cnt;
      filt_done = 1'b0;
      for (int k = 0; k < 3; k++) wait_tick(20, t);
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL sat_stuck got=%b exp=1", busy); end
      overrun_clr = 1'b1;
      @(negedge clk_in);
      overrun_clr = 1'b0;
      checks++; if (overrun !== 1'b0 || ovr_cnt !== 4'd0) begin failures++; $display("FAIL sat_clear got=%b/%0d exp=0/0", overrun, ovr_cnt); end
      for (int k = 1; k <= 20; k++) begin
         wait_tick(20, t);
         exp_cnt = (k > 15) ? 15 : k;
         checks++; if (t < 0 || overrun !== 1'b1 || adc_start !== 1'b0 || ovr_cnt !== 4'(exp_cnt)) begin failures++; $display("FAIL sat_count got=%0d/%b/%b exp=%0d/1/0 drop=%0d", ovr_cnt, overrun, adc_start, exp_cnt, k); end
      end
   endtask

   task automatic test_reset_mid();
      int t, e, p, bad;
      @(negedge clk_in);
      clk_rst = 1'b1;
      @(negedge clk_in);
      checks++; if ({sample_tick, adc_start, filt_start, dac_load, busy, overrun} !== 6'b0 || ovr_cnt !== 4'd0 || cfg_ready !== 1'b1) begin failures++; $display("FAIL midrst_outputs got=%b/%0d/%b exp=000000/0/1", {sample_tick, adc_start, filt_start, dac_load, busy, overrun}, ovr_cnt, cfg_ready); end
      clk_rst = 1'b0;
      filt_done = 1'b1;
      p = cyc;
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_in);
         if (busy !== 1'b0 || dac_load !== 1'b0 || filt_start !== 1'b0) bad++;
      end
      checks++; if (bad !== 0) begin failures++; $display("FAIL midrst_late_done got=%0d exp=0", bad); end
      exp_q.push_back(p + 142);
      wait_tick(300, t);
      e = exp_q.pop_front();
      checks++; if (t !== e) begin failures++; $display("FAIL midrst_tick_time got=%0d exp=%0d", t, e); end
   endtask

   task automatic test_enable_hold();
      int t, e, q;
      enable = 1'b0;
      cfg_div = 8'd4;
      cfg_valid = 1'b1;
      @(negedge clk_in);
      cfg_valid = 1'b0;
      checks++; if (cfg_ready !== 1'b0) begin failures++; $display("FAIL hold_ready_drop got=%b exp=0", cfg_ready); end
      @(negedge clk_in);
      checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL hold_ready_apply got=%b exp=1", cfg_ready); end
      wait_tick(200, t);
      checks++; if (t !== -1) begin failures++; $display("FAIL hold_no_tick got=%0d exp=-1", t); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL hold_busy got=%b exp=0", busy); end
      q = cyc;
      enable = 1'b1;
      exp_q.push_back(q + 5);
      exp_q.push_back(q + 10);
      for (int k = 0; k < 2; k++) begin
         wait_tick(50, t);
         e = exp_q.pop_front();
         checks++; if (t !== e) begin failures++; $display("FAIL hold_tick_time got=%0d exp=%0d", t, e); end
      end
   endtask

`ifdef SAMPLE_WDOG_EN
   task automatic test_wdog();
      int t;
      repeat (4) @(negedge clk_in);
      adc_done = 1'b0;
      wait_tick(20, t);
      checks++; if (adc_start !== 1'b1) begin failures++; $display("FAIL wd_start got=%b exp=1", adc_start); end
      repeat (15) @(negedge clk_in);
      checks++; if (busy !== 1'b1 || wd_timeout !== 1'b0) begin failures++; $display("FAIL wd_before got=%b/%b exp=1/0", busy, wd_timeout); end
      @(negedge clk_in);
      checks++; if (busy !== 1'b0 || wd_timeout !== 1'b1) begin failures++; $display("FAIL wd_fire got=%b/%b exp=0/1", busy, wd_timeout); end
      wait_tick(20, t);
      checks++; if (adc_start !== 1'b1 || wd_timeout !== 1'b1) begin failures++; $display("FAIL wd_restart got=%b/%b exp=1/1", adc_start, wd_timeout); end
      adc_done = 1'b1;
   endtask
`endif

   initial begin
      clk_rst     = 1'b1;
      enable      = 1'b0;
      cfg_div     = 8'd0;
      cfg_valid   = 1'b0;
      adc_done    = 1'b1;
      filt_done   = 1'b1;
      dac_ready   = 1'b1;
      overrun_clr = 1'b0;
      test_reset();
      test_default_period();
      test_cfg();
      test_overrun();
      test_div_zero();
      test_saturate();
      test_reset_mid();
      test_enable_hold();
`ifdef SAMPLE_WDOG_EN
      test_wdog();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
